// File: rtl/regfile_dump_reader.sv
// Walks every register-file address on a read port and streams {addr, data} words out
// over valid/ready. Define REGFILE_DUMP_SKIP_X0_EN to start the walk at x1 instead of x0.
module regfile_dump_reader #(
    parameter int NUM_REGS = 32,
    parameter int ADDR_W   = 5,
    parameter int DATA_W   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              abort,
    output logic [ADDR_W-1:0] A,
    input  logic [DATA_W-1:0] RD,
    output logic [DATA_W-1:0] dout_data,
    output logic [ADDR_W-1:0] dout_addr,
    output logic              dout_valid,
    input  logic              dout_ready,
    output logic              dout_last,
    output logic              busy,
    output logic              done
);

    typedef enum logic [1:0] {IDLE, READ, SEND} state_t;

`ifdef REGFILE_DUMP_SKIP_X0_EN
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(1);
`else
    localparam logic [ADDR_W-1:0] FIRST_ADDR = ADDR_W'(0);
`endif
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(NUM_REGS - 1);

    state_t state, state_nx;
    logic   hs;

    assign hs = dout_valid & dout_ready;

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    // abort outranks a handshake in the same cycle; in IDLE only start matters
    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (start) state_nx = READ;
            READ:    state_nx = abort ? IDLE : SEND;
            SEND: begin
                if (abort)   state_nx = IDLE;
                else if (hs) state_nx = dout_last ? IDLE : READ;
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            A          <= '0;
            dout_data  <= '0;
            dout_addr  <= '0;
            dout_valid <= 1'b0;
            dout_last  <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        A    <= FIRST_ADDR;
                        busy <= 1'b1;
                    end
                end
                READ: begin
                    if (abort) begin
                        busy <= 1'b0;
                    end else begin
                        dout_data  <= RD;
                        dout_addr  <= A;
                        dout_valid <= 1'b1;
                        dout_last  <= (A == LAST_ADDR);
                    end
                end
                SEND: begin
                    if (abort) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        busy       <= 1'b0;
                    end else if (hs) begin
                        dout_valid <= 1'b0;
                        dout_last  <= 1'b0;
                        // last address ends the dump, so A never wraps
                        if (dout_last) begin
                            done <= 1'b1;
                            busy <= 1'b0;
                        end else begin
                            A <= A + ADDR_W'(1);
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_regfile_dump_reader.sv
// Directed bench for regfile_dump_reader: full dump, backpressure, abort, mid-dump reset,
// start-while-busy with a register write during the walk.
module tb_regfile_dump_reader;
    localparam int N  = 32;
    localparam int AW = 5;
    localparam int DW = 32;
`ifdef REGFILE_DUMP_SKIP_X0_EN
    localparam int FIRST = 1;
`else
    localparam int FIRST = 0;
`endif
    localparam int NW = N - FIRST;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic          abort = 1'b0;
    logic          dout_ready = 1'b0;
    logic [AW-1:0] A;
    logic [DW-1:0] RD;
    logic [DW-1:0] dout_data;
    logic [AW-1:0] dout_addr;
    logic          dout_valid, dout_last, busy, done;

    logic [DW-1:0] regs [N];
    assign RD = regs[A];

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    int            q_addr [$];
    logic [DW-1:0] q_data [$];
    bit            q_last [$];

    regfile_dump_reader #(.NUM_REGS(N), .ADDR_W(AW), .DATA_W(DW)) dut (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .A(A), .RD(RD),
        .dout_data(dout_data), .dout_addr(dout_addr), .dout_valid(dout_valid),
        .dout_ready(dout_ready), .dout_last(dout_last),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // start a dump and drive/observe it until done, abort or timeout
    task automatic run(input int stall_at, input int stall_len, input int abort_at,
                       input int poke_at, output int cycles, output bit saw_done);
        int t0, stalled;
        bit both;
        q_addr.delete(); q_data.delete(); q_last.delete();
        stalled  = 0;
        saw_done = 0;
        both     = 0;
        start = 1'b1;
        step();
        start = 1'b0;
        t0 = cyc;
        while (cyc - t0 < 300) begin
            if (done && dout_valid) both = 1;
            if (done) begin saw_done = 1; break; end
            if (!busy) break;
            dout_ready = 1'b1;
            if (dout_valid && int'(dout_addr) == stall_at && stalled < stall_len) begin
                dout_ready = 1'b0;
                stalled++;
                chk("stall_hold_addr", dout_addr, stall_at);
                chk("stall_hold_data", dout_data, stall_at);
            end
            if (dout_valid && int'(dout_addr) == abort_at) begin
                abort = 1'b1;
                step();
                abort = 1'b0;
                break;
            end
            if (dout_valid && int'(dout_addr) == poke_at) begin
                start    = 1'b1;
                regs[20] = 32'h1234_5678;
            end
            if (dout_valid && dout_ready) begin
                q_addr.push_back(int'(dout_addr));
                q_data.push_back(dout_data);
                q_last.push_back(dout_last);
            end
            step();
            start = 1'b0;
        end
        cycles = cyc - t0;
        chk("done_valid_exclusive", both, 0);
    endtask

    task automatic check_words(input int n_exp, input logic [DW-1:0] w20);
        chk("word_count", q_addr.size(), n_exp);
        for (int i = 0; i < q_addr.size(); i++) begin
            chk("word_addr", q_addr[i], FIRST + i);
            chk("word_data", q_data[i], (q_addr[i] == 20) ? w20 : DW'(q_addr[i]));
            chk("word_last", q_last[i], q_addr[i] == N - 1);
        end
    endtask

    initial begin
        int  cycles;
        bit  saw_done;

        for (int i = 0; i < N; i++) regs[i] = DW'(i);

        // reset state
        step(); step();
        chk("rst_A", A, 0);
        chk("rst_dout_data", dout_data, 0);
        chk("rst_dout_addr", dout_addr, 0);
        chk("rst_dout_valid", dout_valid, 0);
        chk("rst_dout_last", dout_last, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        rst = 1'b0;
        step();

        // abort in IDLE has no effect
        abort = 1'b1;
        step();
        abort = 1'b0;
        chk("idle_abort_busy", busy, 0);

        // full dump, ready held high
        run(-1, 0, -1, -1, cycles, saw_done);
        chk("full_done", saw_done, 1);
        chk("full_cycles", cycles, 2 * NW);
        check_words(NW, 32'd20);
        step();
        chk("done_one_cycle", done, 0);
        chk("idle_busy", busy, 0);

        // backpressure: 5 stalled cycles on word 4
        run(4, 5, -1, -1, cycles, saw_done);
        chk("bp_done", saw_done, 1);
        chk("bp_cycles", cycles, 2 * NW + 5);
        check_words(NW, 32'd20);

        // abort on word 10 with ready high
        run(-1, 0, 10, -1, cycles, saw_done);
        chk("abort_no_done", saw_done, 0);
        chk("abort_valid", dout_valid, 0);
        chk("abort_busy", busy, 0);
        chk("abort_done", done, 0);
        chk("abort_words", q_addr.size(), 10 - FIRST);
        step();
        chk("abort_done_later", done, 0);

        // restart after abort begins at the first address
        run(-1, 0, -1, -1, cycles, saw_done);
        chk("restart_done", saw_done, 1);
        check_words(NW, 32'd20);

        // reset while A=7
        dout_ready = 1'b1;
        start = 1'b1;
        step();
        start = 1'b0;
        for (int k = 0; k < 100 && A != 7; k++) step();
        chk("reach_a7", A, 7);
        rst = 1'b1;
        step();
        rst = 1'b0;
        chk("mid_rst_A", A, 0);
        chk("mid_rst_valid", dout_valid, 0);
        chk("mid_rst_data", dout_data, 0);
        chk("mid_rst_addr", dout_addr, 0);
        chk("mid_rst_last", dout_last, 0);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_done", done, 0);
        run(-1, 0, -1, -1, cycles, saw_done);
        chk("post_rst_done", saw_done, 1);
        chk("post_rst_cycles", cycles, 2 * NW);
        check_words(NW, 32'd20);

        // start while busy on word 3, register 20 rewritten before it is read
        run(-1, 0, -1, 3, cycles, saw_done);
        chk("busy_start_done", saw_done, 1);
        chk("busy_start_cycles", cycles, 2 * NW);
        check_words(NW, 32'h1234_5678);
        step();
        chk("busy_start_no_rerun", busy, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
